multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised multi-channel successor to the single-channel MIPS CPU interval timer.
- N_CH independent down-counters of CNT_W bits behind one memory-mapped word-register slave port.
- Three modes per channel: one-shot, auto-reload, square-wave.
- Sticky write-1-to-clear status per channel; one level interrupt line plus a per-channel vector to the CP0/interrupt-controller bridge.

Parameters:
- N_CH, 2: number of timer channels (1..8).
- CNT_W, 32: counter/preset width (8..32); upper dat bits are ignored on write and read as 0.
- AW, $clog2(N_CH)+2 (derived localparam, min 2): word-address width, {channel, reg[1:0]}.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- add_i  in  AW  word address: add_i[AW-1:2] = channel, add_i[1:0] = register.
- we_i  in  1  write enable, sampled at posedge clk_i.
- dat_i  in  32  write data.
- dat_o  out  32  read data, combinational from add_i.
- irq_o  out  1  OR of all per-channel masked pending bits.
- irq_vec_o  out  N_CH  per-channel masked pending (pend & IM).
- wave_o  out  N_CH  square-wave outputs.

Behaviour:
- Reset is asynchronous and active-low: one clock, clk_i; reset rst_ni asserted low clears all registers immediately, independent of clk_i.
  - Reset values: CTRL = 0, PRESET = 0, COUNT = 0, pend = 0, wave = 0, so irq_o = 0 and irq_vec_o = 0.
- Register map per channel (reg index):
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 PRESET: R/W.
  - 2 COUNT: read-only; writes ignored.
  - 3 STATUS: [0] pend, write 1 clears; writing 0 has no effect.
- MODE encoding: 00 one-shot, 01 auto-reload, 10 square-wave, 11 reserved (channel holds COUNT, never expires).
- Reads:
  - dat_o is zero-extended.
  - A channel index >= N_CH reads 0; writes to it are ignored.
- PRESET write: COUNT <= dat_i[CNT_W-1:0] on the same edge, regardless of EN.
- Counting: while EN = 1 and COUNT != 0, COUNT decrements by 1 per clk_i.
  - EN written 1 at edge t gives the first decrement at edge t+1.
- Expiry event: EN = 1 and COUNT == 0 at a clock edge.
  - Mode 00: EN <= 0, COUNT stays 0, pend <= 1.
  - Mode 01: COUNT <= PRESET, pend <= 1.
  - Mode 10: COUNT <= PRESET, wave toggles, pend <= 1.
  - Reload period is therefore PRESET+1 cycles. PRESET = 0 in modes 01/10 expires every cycle (wave = clk/2).
- pend is set regardless of IM. IM only gates irq_vec_o/irq_o, which are level outputs held until pend is cleared or IM = 0.
- EN = 0 freezes COUNT and wave. Mode 00 after expiry requires software to write PRESET and set EN again.
- Simultaneous events, same edge:
  - Expiry and STATUS W1C: set wins, pend stays 1.
  - Expiry and CTRL write: written CTRL value wins; the expiry's EN clear is discarded. pend is still set and the reload still happens.
  - Expiry and PRESET write: COUNT takes the new dat_i value; pend is still set; wave still toggles in mode 10.
- Changing MODE mid-count does not touch COUNT. Leaving mode 10 holds wave at its current value.
- Reset asserted mid-count returns the channel to reset values immediately. Counting resumes only after software reprograms the channel.

Decomposition:
- Shared package timer_pkg:
  - reg index constants REG_CTRL = 0, REG_PRESET = 1, REG_COUNT = 2, REG_STATUS = 3;
  - mode constants MODE_ONESHOT, MODE_RELOAD, MODE_WAVE;
  - CTRL bit positions EN_B, MODE_LSB, IM_B.
- One sub-module, timer_chan:
  - one channel's CTRL/PRESET/COUNT/pend/wave;
  - inputs: decoded per-register write strobes and dat_i;
  - instantiated N_CH times by a generate loop in multi_timer.
- The top level holds only address decode, the read mux, and the irq OR.

Test Plan:
1. One-shot: reset, ch0 PRESET = 5, CTRL = 0x9 (EN, mode 00, IM) -> COUNT reads 5,4,3,2,1,0 on successive cycles; expiry after 6 cycles sets pend, irq_o = 1, EN reads 0, COUNT holds 0; W1C STATUS = 1 -> irq_o = 0 next cycle.
2. Auto-reload: ch1 PRESET = 3, CTRL = 0x3, IM = 0 -> pend set every 4 cycles, irq_o stays 0, irq_vec_o = 0; set IM -> irq_vec_o = 2'b10.
3. Square wave: ch0 PRESET = 2, CTRL = 0x5 -> wave_o[0] toggles every 3 cycles (period 6); PRESET = 0 -> toggles every cycle.
4. Collisions: W1C STATUS on the exact expiry edge -> pend remains 1; CTRL write of 0x1 on a mode-00 expiry edge -> EN reads 1.
5. Async reset mid-count (COUNT = 0x10, pend = 1): drop rst_ni between clock edges -> all registers, irq_o and wave_o read 0 before the next edge.
6. Widths/decode: CNT_W = 8, PRESET write 0x1FF -> reads 0xFF; read channel index >= N_CH -> 0; write to COUNT -> unchanged.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
//   Register indices, mode encodings, CTRL bit positions and the CTRL payload
//   struct used between multi_timer and timer_chan.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 2;

  localparam logic [REG_W-1:0] REG_CTRL   = 2'd0;
  localparam logic [REG_W-1:0] REG_PRESET = 2'd1;
  localparam logic [REG_W-1:0] REG_COUNT  = 2'd2;
  localparam logic [REG_W-1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_WAVE    = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam int unsigned EN_B     = 0;
  localparam int unsigned MODE_LSB = 1;
  localparam int unsigned IM_B     = 3;

  // Packed so that its bit layout equals the CTRL register layout.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Extract CTRL fields from a write word.
  function automatic ctrl_t ctrl_decode(input logic [7:0] d);
    ctrl_t c;
    c.en   = d[EN_B];
    c.mode = d[MODE_LSB +: 2];
    c.im   = d[IM_B];
    return c;
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: CTRL, PRESET, COUNT, sticky pend and square-wave output.
//   clk_i, rst_ni        clock, async active-low reset
//   ctrl_we/preset_we/status_we  decoded write strobes for this channel
//   wdat                 write data, already truncated to CNT_W
//   ctrl, preset, count, pend, wave  registered channel state
module timer_chan
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [CNT_W-1:0] wdat,
  output ctrl_t            ctrl,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pend,
  output logic             wave
);

  logic expire_c;

  // Reserved mode never expires and holds COUNT.
  assign expire_c = ctrl.en && (count == '0) && (ctrl.mode != MODE_RSVD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
      wave   <= 1'b0;
    end else begin
      // A CTRL write overrides the one-shot self-disable.
      if (ctrl_we) begin
        ctrl <= ctrl_decode(wdat[7:0]);
      end else if (expire_c && (ctrl.mode == MODE_ONESHOT)) begin
        ctrl.en <= 1'b0;
      end

      if (preset_we) begin
        preset <= wdat;
      end

      // PRESET write beats both reload and decrement.
      if (preset_we) begin
        count <= wdat;
      end else if (expire_c) begin
        if (ctrl.mode != MODE_ONESHOT) begin
          count <= preset;
        end
      end else if (ctrl.en && (ctrl.mode != MODE_RSVD) && (count != '0)) begin
        count <= count - CNT_W'(1);
      end

      // Set has priority over write-1-to-clear.
      if (expire_c) begin
        pend <= 1'b1;
      end else if (status_we && wdat[0]) begin
        pend <= 1'b0;
      end

      if (expire_c && (ctrl.mode == MODE_WAVE)) begin
        wave <= ~wave;
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel interval timer with a word-register slave port.
//   clk_i, rst_ni  clock, async active-low reset
//   add_i          {channel, reg[1:0]} word address
//   we_i, dat_i    write enable and data
//   dat_o          combinational read data for add_i
//   irq_o          OR of all masked pending bits
//   irq_vec_o      per-channel pend & IM
//   wave_o         per-channel square-wave outputs
module multi_timer
  import timer_pkg::*;
#(
  parameter  int unsigned N_CH  = 2,
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned AW    = $clog2(N_CH) + 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AW-1:0]     add_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              irq_o,
  output logic [N_CH-1:0]   irq_vec_o,
  output logic [N_CH-1:0]   wave_o
);

  localparam int unsigned CH_W = (AW > 2) ? (AW - 2) : 1;

  logic [CH_W-1:0]  chan_c;
  logic [REG_W-1:0] reg_c;
  logic [CNT_W-1:0] wdat_c;
  logic             unused_dat;

  ctrl_t            ctrl   [N_CH];
  logic [CNT_W-1:0] preset [N_CH];
  logic [CNT_W-1:0] count  [N_CH];
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  wave;

  // Address split; a single channel has no channel field.
  if (AW > 2) begin : g_chan
    assign chan_c = add_i[AW-1:2];
  end else begin : g_chan_one
    assign chan_c = '0;
  end

  assign reg_c      = add_i[1:0];
  assign wdat_c     = dat_i[CNT_W-1:0];
  assign unused_dat = ^dat_i;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit_c;
    assign hit_c = we_i && (chan_c == CH_W'(i));

    timer_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ctrl_we   (hit_c && (reg_c == REG_CTRL)),
      .preset_we (hit_c && (reg_c == REG_PRESET)),
      .status_we (hit_c && (reg_c == REG_STATUS)),
      .wdat      (wdat_c),
      .ctrl      (ctrl[i]),
      .preset    (preset[i]),
      .count     (count[i]),
      .pend      (pend[i]),
      .wave      (wave[i])
    );

    assign irq_vec_o[i] = pend[i] & ctrl[i].im;
  end

  assign irq_o  = |irq_vec_o;
  assign wave_o = wave;

  // Read mux; unpopulated channel indices read zero.
  always_comb begin
    dat_o = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (chan_c == CH_W'(i)) begin
        case (reg_c)
          REG_CTRL:   dat_o = DATA_W'(ctrl[i]);
          REG_PRESET: dat_o = DATA_W'(preset[i]);
          REG_COUNT:  dat_o = DATA_W'(count[i]);
          default:    dat_o = DATA_W'(pend[i]);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (3 channels, 8-bit counters).
module tb_multi_timer;
  import timer_pkg::*;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned HALF  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     add = '0;
  logic              we = 1'b0;
  logic [31:0]       wdat = '0;
  logic [31:0]       rdat;
  logic              irq;
  logic [N_CH-1:0]   irq_vec;
  logic [N_CH-1:0]   wave;

  int n_chk  = 0;
  int n_pass = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #HALF clk = ~clk;

  multi_timer #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .add_i     (add),
    .we_i      (we),
    .dat_i     (wdat),
    .dat_o     (rdat),
    .irq_o     (irq),
    .irq_vec_o (irq_vec),
    .wave_o    (wave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [AW-1:0] a(input int unsigned ch, input logic [1:0] r);
    return AW'(ch * 4 + 32'(r));
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Reads are combinational; called in the low phase of clk.
  task automatic rd(input int unsigned ch, input logic [1:0] r, output logic [31:0] v);
    add = a(ch, r);
    #1;
    v = rdat;
  endtask

  task automatic rd_exp(input int unsigned ch, input logic [1:0] r, input string tag,
                        input logic [31:0] exp);
    logic [31:0] v;
    push(tag, exp);
    rd(ch, r, v);
    pop_cmp(v);
  endtask

  // Write spans exactly one rising edge.
  task automatic wr(input int unsigned ch, input logic [1:0] r, input logic [31:0] d);
    add  = a(ch, r);
    wdat = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    step(2);
    rd_exp(0, REG_CTRL,   "rst_ctrl0",   32'h0);
    rd_exp(1, REG_PRESET, "rst_preset1", 32'h0);
    rd_exp(0, REG_COUNT,  "rst_count0",  32'h0);
    rd_exp(2, REG_STATUS, "rst_status2", 32'h0);
    check("rst_irq",  32'(irq),  32'h0);
    check("rst_wave", 32'(wave), 32'h0);
    rst_n = 1'b1;
    step(1);

    // One-shot on ch0
    wr(0, REG_PRESET, 32'd5);
    wr(0, REG_CTRL, 32'h9);
    for (int k = 0; k < 6; k++) push($sformatf("os_count%0d", k), 32'(5 - k));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(1);
      rd(0, REG_COUNT, v);
      pop_cmp(v);
    end
    check("os_irq_before", 32'(irq), 32'h0);
    step(1);
    rd_exp(0, REG_STATUS, "os_pend", 32'h1);
    rd_exp(0, REG_CTRL,   "os_en_clr", 32'h8);
    rd_exp(0, REG_COUNT,  "os_count_hold", 32'h0);
    check("os_irq",     32'(irq),     32'h1);
    check("os_irq_vec", 32'(irq_vec), 32'h1);
    wr(0, REG_STATUS, 32'h1);
    check("os_irq_w1c", 32'(irq), 32'h0);

    // Auto-reload on ch1, IM off then on
    wr(1, REG_PRESET, 32'd3);
    wr(1, REG_CTRL, 32'h3);
    step(3);
    rd_exp(1, REG_STATUS, "ar_pend_early", 32'h0);
    step(1);
    rd_exp(1, REG_STATUS, "ar_pend1", 32'h1);
    check("ar_irq_masked", 32'(irq),     32'h0);
    check("ar_vec_masked", 32'(irq_vec), 32'h0);
    wr(1, REG_STATUS, 32'h1);
    rd_exp(1, REG_STATUS, "ar_cleared", 32'h0);
    step(2);
    rd_exp(1, REG_STATUS, "ar_pend_gap", 32'h0);
    step(1);
    rd_exp(1, REG_STATUS, "ar_pend2", 32'h1);
    wr(1, REG_CTRL, 32'hB);
    check("ar_vec_im", 32'(irq_vec), 32'h2);
    check("ar_irq_im", 32'(irq),     32'h1);
    wr(1, REG_CTRL, 32'h0);
    wr(1, REG_STATUS, 32'h1);
    check("ar_irq_off", 32'(irq), 32'h0);

    // Square wave on ch0: PRESET=2 then PRESET=0
    wr(0, REG_PRESET, 32'd2);
    wr(0, REG_CTRL, 32'h5);
    for (int k = 0; k < 10; k++) push($sformatf("sq3_wave%0d", k), 32'((k / 3) % 2));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      pop_cmp(32'(wave[0]));
    end
    rd_exp(0, REG_STATUS, "sq_pend", 32'h1);
    check("sq_irq_masked", 32'(irq), 32'h0);
    wr(0, REG_PRESET, 32'd0);
    for (int k = 0; k < 4; k++) push($sformatf("sq1_wave%0d", k), 32'((k + 1) % 2));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      pop_cmp(32'(wave[0]));
    end
    step(1);
    wr(0, REG_CTRL, 32'h0);
    step(2);
    check("sq_frozen", 32'(wave[0]), 32'h0);
    wr(0, REG_STATUS, 32'h1);

    // Collision: W1C on the expiry edge
    wr(0, REG_PRESET, 32'd3);
    wr(0, REG_CTRL, 32'h3);
    step(3);
    rd_exp(0, REG_STATUS, "col_w1c_pre", 32'h0);
    wr(0, REG_STATUS, 32'h1);
    rd_exp(0, REG_STATUS, "col_w1c_set_wins", 32'h1);
    rd_exp(0, REG_COUNT,  "col_w1c_reload", 32'h3);
    wr(0, REG_CTRL, 32'h0);
    wr(0, REG_STATUS, 32'h1);

    // Collision: CTRL write on a one-shot expiry edge
    wr(0, REG_PRESET, 32'd2);
    wr(0, REG_CTRL, 32'h1);
    step(2);
    wr(0, REG_CTRL, 32'h1);
    rd_exp(0, REG_CTRL,   "col_ctrl_en", 32'h1);
    rd_exp(0, REG_STATUS, "col_ctrl_pend", 32'h1);
    rd_exp(0, REG_COUNT,  "col_ctrl_count", 32'h0);
    step(1);
    rd_exp(0, REG_CTRL, "col_ctrl_reexpire", 32'h0);
    wr(0, REG_STATUS, 32'h1);

    // Collision: PRESET write on a reload expiry edge
    wr(1, REG_PRESET, 32'd1);
    wr(1, REG_CTRL, 32'h3);
    step(1);
    wr(1, REG_PRESET, 32'd7);
    rd_exp(1, REG_COUNT,  "col_preset_count", 32'h7);
    rd_exp(1, REG_STATUS, "col_preset_pend", 32'h1);
    wr(1, REG_CTRL, 32'h0);
    wr(1, REG_STATUS, 32'h1);

    // Async reset mid-count: ch0 wave parked at 1, ch2 COUNT=0x10 with pend
    wr(0, REG_PRESET, 32'd0);
    wr(0, REG_CTRL, 32'h5);
    wr(0, REG_CTRL, 32'h4);
    check("pre_rst_wave", 32'(wave), 32'h1);
    wr(2, REG_CTRL, 32'hB);
    step(1);
    wr(2, REG_PRESET, 32'h10);
    rd_exp(2, REG_COUNT,  "pre_rst_count", 32'h10);
    rd_exp(2, REG_STATUS, "pre_rst_pend", 32'h1);
    check("pre_rst_irq", 32'(irq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq",     32'(irq),     32'h0);
    check("arst_irq_vec", 32'(irq_vec), 32'h0);
    check("arst_wave",    32'(wave),    32'h0);
    rd_exp(2, REG_COUNT,  "arst_count2",  32'h0);
    rd_exp(2, REG_STATUS, "arst_status2", 32'h0);
    rd_exp(2, REG_CTRL,   "arst_ctrl2",   32'h0);
    rd_exp(2, REG_PRESET, "arst_preset2", 32'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    rd_exp(2, REG_COUNT,  "post_rst_idle", 32'h0);
    rd_exp(2, REG_STATUS, "post_rst_pend", 32'h0);

    // Width truncation and address decode
    wr(1, REG_PRESET, 32'h1FF);
    rd_exp(1, REG_PRESET, "w_preset_trunc", 32'hFF);
    rd_exp(1, REG_COUNT,  "w_count_load",  32'hFF);
    wr(1, REG_COUNT, 32'h12);
    rd_exp(1, REG_COUNT,  "w_count_ro",    32'hFF);
    wr(0, REG_CTRL, 32'hFFFF_FFF6);
    rd_exp(0, REG_CTRL,   "w_ctrl_bits",   32'h6);
    wr(3, REG_CTRL, 32'hF);
    rd_exp(3, REG_CTRL,   "w_ch3_ctrl",    32'h0);
    wr(3, REG_PRESET, 32'h55);
    rd_exp(3, REG_PRESET, "w_ch3_preset",  32'h0);
    rd_exp(0, REG_CTRL,   "w_ch0_untouched", 32'h6);
    rd_exp(2, REG_CTRL,   "w_ch2_untouched", 32'h0);
    rd_exp(1, REG_PRESET, "w_ch1_untouched", 32'hFF);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
